// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and transmit FSM state encoding for the UART
// transmit path. The encoding is the same whether or not the optional parity
// state (UART_TX_PARITY_EN) is built in, so TX_PARITY always keeps its value.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: single-clock synchronous FIFO holding bytes waiting to be
// serialised.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   push, push_data  write request; ignored while full
//   pop, pop_data    read request; pop_data shows the head (valid when !empty)
//   full, empty      occupancy flags
//   count            number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = UART_DATA_BITS,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem[rd_ptr];

   // Flags come from the registered count, so a write into an empty FIFO only
   // becomes poppable on the following cycle, and a write while full is lost
   // even if a pop happens in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: UART transmitter with a byte FIFO in front. Bytes written
// on the valid/ready port are queued and sent as 8N1 frames, LSB first, with
// back-to-back frames sent without an idle gap.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit after the
// data bits (8E1, 11-bit frames).
// Ports:
//   i_Clock, i_Reset   clock, synchronous active-high reset
//   i_Tx_DV, i_Tx_Byte write strobe and byte; accepted when o_Tx_Ready
//   o_Tx_Ready         FIFO not full
//   o_Tx_Overflow      1-cycle pulse after a write that found the FIFO full
//   o_Fifo_Count       queued bytes, not counting the one being sent
//   o_Tx_Active        high from the first start-bit cycle to the last stop-bit cycle
//   o_Tx_Serial        serial line, idle high
//   o_Tx_Done          1-cycle pulse on the cycle after the last stop-bit cycle
//
// state     | meaning
// ----------+-----------------------------------------------------------
// TX_IDLE   | line high, waiting for a queued byte
// TX_START  | start bit (0)
// TX_DATA   | data bits 0..7, LSB first
// TX_PARITY | even parity of the data byte (UART_TX_PARITY_EN only)
// TX_STOP   | stop bit (1); chains straight into TX_START if bytes are queued
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int FIFO_DEPTH   = 16,
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             i_Clock,
   input  logic             i_Reset,
   input  logic             i_Tx_DV,
   input  logic [7:0]       i_Tx_Byte,
   output logic             o_Tx_Ready,
   output logic             o_Tx_Overflow,
   output logic [CNT_W-1:0] o_Fifo_Count,
   output logic             o_Tx_Active,
   output logic             o_Tx_Serial,
   output logic             o_Tx_Done
);

   localparam int TMR_W = $clog2(CLKS_PER_BIT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

   tx_state_t  state;
   logic [TMR_W-1:0] tmr;
   logic [2:0] bit_idx;
   logic [7:0] shift_q;
   logic       serial_q;
   logic       active_q;
   logic       done_q;
   logic       ovf_q;
   logic       tmr_last;
   logic       fifo_pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_data;
`ifdef UART_TX_PARITY_EN
   logic       parity_q;
`endif

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk       (i_Clock),
      .reset     (i_Reset),
      .push      (i_Tx_DV),
      .push_data (i_Tx_Byte),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (o_Fifo_Count)
   );

   assign tmr_last = (tmr == TMR_LAST);

   // Pop when idle, or on the last stop-bit cycle so the next start bit
   // follows immediately.
   always_comb begin
      fifo_pop = 1'b0;
      if (!fifo_empty) begin
         if (state == TX_IDLE)                  fifo_pop = 1'b1;
         else if (state == TX_STOP && tmr_last) fifo_pop = 1'b1;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state    <= TX_IDLE;
         tmr      <= '0;
         bit_idx  <= '0;
         shift_q  <= '0;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         ovf_q  <= i_Tx_DV && fifo_full;
         case (state)
            TX_IDLE: begin
               tmr      <= '0;
               serial_q <= 1'b1;
               if (fifo_pop) begin
                  shift_q  <= fifo_data;
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^fifo_data;
`endif
                  serial_q <= 1'b0;
                  active_q <= 1'b1;
                  state    <= TX_START;
               end
            end
            TX_START: begin
               if (tmr_last) begin
                  tmr      <= '0;
                  bit_idx  <= '0;
                  serial_q <= shift_q[0];
                  state    <= TX_DATA;
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end
            TX_DATA: begin
               if (tmr_last) begin
                  tmr <= '0;
                  if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                     serial_q <= parity_q;
                     state    <= TX_PARITY;
`else
                     serial_q <= 1'b1;
                     state    <= TX_STOP;
`endif
                  end else begin
                     bit_idx  <= bit_idx + 3'd1;
                     shift_q  <= shift_q >> 1;
                     serial_q <= shift_q[1];
                  end
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
               if (tmr_last) begin
                  tmr      <= '0;
                  serial_q <= 1'b1;
                  state    <= TX_STOP;
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end
`endif
            TX_STOP: begin
               if (tmr_last) begin
                  tmr    <= '0;
                  done_q <= 1'b1;
                  if (fifo_pop) begin
                     shift_q  <= fifo_data;
`ifdef UART_TX_PARITY_EN
                     parity_q <= ^fifo_data;
`endif
                     serial_q <= 1'b0;
                     state    <= TX_START;
                  end else begin
                     active_q <= 1'b0;
                     state    <= TX_IDLE;
                  end
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end
            default: begin
               tmr      <= '0;
               serial_q <= 1'b1;
               active_q <= 1'b0;
               state    <= TX_IDLE;
            end
         endcase
      end
   end

   assign o_Tx_Ready    = !fifo_full;
   assign o_Tx_Overflow = ovf_q;
   assign o_Tx_Active   = active_q;
   assign o_Tx_Serial   = serial_q;
   assign o_Tx_Done     = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Written bytes go into an expected-byte queue; a line monitor decodes every
// frame cycle by cycle against the popped byte. Honours UART_TX_PARITY_EN.
module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic       i_Clock   = 1'b0;
   logic       i_Reset   = 1'b1;
   logic       i_Tx_DV   = 1'b0;
   logic [7:0] i_Tx_Byte = 8'h00;
   logic       o_Tx_Ready;
   logic       o_Tx_Overflow;
   logic [2:0] o_Fifo_Count;
   logic       o_Tx_Active;
   logic       o_Tx_Serial;
   logic       o_Tx_Done;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   int cyc = 0;
   int done_cnt = 0;
   int ovf_cnt = 0;
   int frames = 0;
   int last_done_cyc = 0;
   bit mon_en = 0;
   bit mon_busy = 0;
   bit done_exp = 0;
   int mon_idx = 0;
   logic [10:0] exp_bits = '1;
   logic [7:0]  mon_byte;
   logic [7:0]  exp_q[$];
   int          starts[$];

   uart_tx_buffered #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .i_Clock       (i_Clock),
      .i_Reset       (i_Reset),
      .i_Tx_DV       (i_Tx_DV),
      .i_Tx_Byte     (i_Tx_Byte),
      .o_Tx_Ready    (o_Tx_Ready),
      .o_Tx_Overflow (o_Tx_Overflow),
      .o_Fifo_Count  (o_Fifo_Count),
      .o_Tx_Active   (o_Tx_Active),
      .o_Tx_Serial   (o_Tx_Serial),
      .o_Tx_Done     (o_Tx_Done)
   );

   always #5 i_Clock = ~i_Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] build_frame(input logic [7:0] b);
      logic [10:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = b;
`ifdef UART_TX_PARITY_EN
      f[9]   = ^b;
`endif
      return f;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge i_Clock);
         #1;
      end
   endtask

   task automatic write_byte(input logic [7:0] b, input bit accept);
      i_Tx_DV   = 1'b1;
      i_Tx_Byte = b;
      @(posedge i_Clock);
      #1;
      i_Tx_DV   = 1'b0;
      i_Tx_Byte = 8'h00;
      if (accept) exp_q.push_back(b);
   endtask

   task automatic wait_done(input string tag, input int target, input int budget);
      int k;
      k = 0;
      while (done_cnt < target && k < budget) begin
         @(posedge i_Clock);
         #1;
         k++;
      end
      check(tag, done_cnt >= target, 1);
   endtask

   // Line monitor: samples on the falling edge, away from the active edge.
   initial begin
      forever begin
         @(negedge i_Clock);
         cyc++;
         if (o_Tx_Overflow === 1'b1) ovf_cnt++;
         if (o_Tx_Done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
         end
         if (mon_en) begin
            if (i_Reset) begin
               mon_busy = 0;
               done_exp = 0;
            end else begin
               check("done_pulse", o_Tx_Done, done_exp);
               done_exp = 0;
               if (mon_busy) begin
                  check("serial_bit", o_Tx_Serial, exp_bits[mon_idx / CPB]);
                  check("active_in_frame", o_Tx_Active, 1);
                  mon_idx++;
                  if (mon_idx == FRAME) begin
                     mon_busy = 0;
                     done_exp = 1;
                  end
               end else if (o_Tx_Serial === 1'b0) begin
                  check("frame_expected", exp_q.size() > 0, 1);
                  mon_byte = 8'h00;
                  if (exp_q.size() > 0) mon_byte = exp_q.pop_front();
                  exp_bits = build_frame(mon_byte);
                  starts.push_back(cyc);
                  frames++;
                  check("active_at_start", o_Tx_Active, 1);
                  mon_idx  = 1;
                  mon_busy = 1;
               end else begin
                  check("idle_active", o_Tx_Active, 0);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n0;
      int d0;
      int f0;
      int o0;
      int g1;
      int g2;

      // Reset held for three cycles.
      i_Reset = 1'b1;
      repeat (2) @(posedge i_Clock);
      @(negedge i_Clock);
      check("rst_serial", o_Tx_Serial, 1);
      check("rst_ready", o_Tx_Ready, 1);
      check("rst_count", o_Fifo_Count, 0);
      check("rst_active", o_Tx_Active, 0);
      check("rst_done", o_Tx_Done, 0);
      check("rst_overflow", o_Tx_Overflow, 0);
      @(posedge i_Clock);
      #1;
      i_Reset = 1'b0;
      mon_en  = 1;
      tick(5);

      // Single byte: start bit at N+2, done at N+2+FRAME.
      starts.delete();
      d0 = done_cnt;
      n0 = cyc + 1;
      write_byte(8'hA5, 1);
      wait_done("single_wait", d0 + 1, FRAME + 20);
      check("single_start_cyc", (starts.size() > 0) ? starts[0] : -1, n0 + 2);
      check("single_done_cyc", last_done_cyc, n0 + 2 + FRAME);
      tick(5);

      // Burst of three: contiguous frames, exactly three done pulses.
      starts.delete();
      d0 = done_cnt;
      write_byte(8'h01, 1);
      write_byte(8'h02, 1);
      write_byte(8'h03, 1);
      wait_done("burst_wait", d0 + 3, 3 * FRAME + 30);
      tick(10);
      g1 = (starts.size() >= 2) ? starts[1] - starts[0] : -1;
      g2 = (starts.size() >= 3) ? starts[2] - starts[1] : -1;
      check("burst_frames", starts.size(), 3);
      check("burst_gap1", g1, FRAME);
      check("burst_gap2", g2, FRAME);
      check("burst_done_cnt", done_cnt - d0, 3);

      // Fill: six writes from idle; one popped, four queued, sixth dropped.
      d0 = done_cnt;
      o0 = ovf_cnt;
      for (int i = 0; i < 6; i++) write_byte(8'h10 + 8'(i), i < 5);
      @(negedge i_Clock);
      check("fill_overflow", o_Tx_Overflow, 1);
      check("fill_count", o_Fifo_Count, 4);
      check("fill_ready", o_Tx_Ready, 0);
      @(posedge i_Clock);
      #1;
      wait_done("fill_wait", d0 + 5, 5 * FRAME + 40);
      tick(10);
      check("fill_ovf_pulses", ovf_cnt - o0, 1);
      check("fill_done_cnt", done_cnt - d0, 5);
      check("fill_queue_empty", exp_q.size(), 0);
      check("fill_ready_after", o_Tx_Ready, 1);

      // Reset in the middle of DATA of 0xFF with two bytes queued.
      d0 = done_cnt;
      f0 = frames;
      write_byte(8'hFF, 1);
      write_byte(8'h11, 1);
      write_byte(8'h22, 1);
      tick(20);
      @(negedge i_Clock);
      check("midrst_count_before", o_Fifo_Count, 2);
      check("midrst_active_before", o_Tx_Active, 1);
      @(posedge i_Clock);
      #1;
      i_Reset = 1'b1;
      @(posedge i_Clock);
      #1;
      i_Reset = 1'b0;
      exp_q.delete();
      @(negedge i_Clock);
      check("midrst_serial", o_Tx_Serial, 1);
      check("midrst_count", o_Fifo_Count, 0);
      check("midrst_active", o_Tx_Active, 0);
      check("midrst_ready", o_Tx_Ready, 1);
      @(posedge i_Clock);
      #1;
      tick(100);
      check("midrst_no_frames", frames - f0, 1);
      check("midrst_no_done", done_cnt - d0, 0);
      check("midrst_line_idle", o_Tx_Serial, 1);

      // Parity-sensitive bytes; frame length follows the build.
      starts.delete();
      d0 = done_cnt;
      write_byte(8'h07, 1);
      wait_done("par07_wait", d0 + 1, FRAME + 20);
      check("par07_len", (starts.size() > 0) ? last_done_cyc - starts[0] : -1, FRAME);
      tick(3);
      write_byte(8'h03, 1);
      wait_done("par03_wait", d0 + 2, FRAME + 20);
      check("par03_len", (starts.size() > 1) ? last_done_cyc - starts[1] : -1, FRAME);
      tick(5);
      check("final_queue_empty", exp_q.size(), 0);
      check("final_serial", o_Tx_Serial, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
